adbg_crc_engine: RTL and testbench

Parametrised, word-wide CRC engine for the advanced debug module. It generalises the bit-serial debug CRC to any CRC width, reversed polynomial and beat width, with partial last beats. A built-in serialiser shifts the result out LSB-first under a valid/ready handshake. It sits between the debug-module shift datapath (accumulate on receive, serialise on transmit) and the TAP TDO mux.

---
 rtl/adbg_crc_pkg.sv | 24 ++
 rtl/adbg_crc_step.sv | 41 ++++
 rtl/adbg_crc_engine.sv | 138 +++++++++++++
 tb/tb_adbg_crc_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_crc_pkg.sv
// Shared definitions for the advanced-debug CRC engine: state encoding,
// default polynomial/seed and the single-bit LSB-first CRC step.
package adbg_crc_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SHIFT = 1'b1
    } crc_state_e;

    localparam logic [31:0] CRC_POLY_REV_DEF = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT_DEF     = 32'hFFFFFFFF;

    // One reflected CRC step; poly must already be masked to the CRC width.
    function automatic logic [31:0] crc_bit_step(
        input logic [31:0] crc,
        input logic        bit_in,
        input logic [31:0] poly
    );
        logic fb;
        fb = bit_in ^ crc[0];
        return (crc >> 1) ^ (fb ? poly : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/adbg_crc_step.sv
// Combinational DATA_W-deep chain of CRC bit steps; bits at or above the
// effective bit count pass the CRC through unchanged.
module adbg_crc_step
    import adbg_crc_pkg::*;
#(
    parameter int          CRC_W    = 32,
    parameter logic [31:0] POLY_REV = CRC_POLY_REV_DEF,
    parameter int          DATA_W   = 8,
    parameter int          NB_W     = $clog2(DATA_W) + 1
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [NB_W-1:0]   nbits,
    output logic [CRC_W-1:0]  crc_out
);

    localparam logic [31:0]     POLY_M  = POLY_REV & (32'hFFFF_FFFF >> (32 - CRC_W));
    localparam logic [NB_W-1:0] DATA_NB = NB_W'(DATA_W);

    logic [NB_W-1:0] nb_eff_s;
    logic [31:0]     chain_s;

    // Zero and oversize counts both mean a full beat.
    assign nb_eff_s = ((nbits == {NB_W{1'b0}}) || (nbits > DATA_NB)) ? DATA_NB : nbits;

    // Unrolled bit-serial chain, bit 0 first.
    always_comb begin
        chain_s = 32'h0000_0000;
        chain_s[CRC_W-1:0] = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (NB_W'(i) < nb_eff_s) begin
                chain_s = crc_bit_step(chain_s, data[i], POLY_M);
            end else begin
                chain_s = chain_s;
            end
        end
    end

    assign crc_out = chain_s[CRC_W-1:0];

endmodule

// File: rtl/adbg_crc_engine.sv
// Word-wide CRC engine with an LSB-first serialiser for the debug TDO path.
// Optional ADBG_CRC_MATCH_EN adds the zero-residue flag and sticky match_seen.
module adbg_crc_engine
    import adbg_crc_pkg::*;
#(
    parameter int          CRC_W    = 32,
    parameter logic [31:0] POLY_REV = CRC_POLY_REV_DEF,
    parameter logic [31:0] INIT     = CRC_INIT_DEF,
    parameter int          DATA_W   = 8,
    parameter int          NB_W     = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NB_W-1:0]   in_nbits,
    input  logic              start_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              serial_out,
    output logic              out_last,
    output logic [CRC_W-1:0]  crc_out
`ifdef ADBG_CRC_MATCH_EN
    ,
    output logic              crc_match,
    output logic              match_seen
`endif
);

    localparam int               CNT_W    = $clog2(CRC_W);
    localparam logic [CRC_W-1:0] INIT_C   = INIT[CRC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

    crc_state_e       state_r, state_s;
    logic [CRC_W-1:0] crc_r, crc_s, step_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    adbg_crc_step #(
        .CRC_W    (CRC_W),
        .POLY_REV (POLY_REV),
        .DATA_W   (DATA_W),
        .NB_W     (NB_W)
    ) u_step (
        .crc_in  (crc_r),
        .data    (in_data),
        .nbits   (in_nbits),
        .crc_out (step_s)
    );

    // Next-state: clr wins; RUN absorbs a beat before honouring start_out.
    always_comb begin
        state_s = state_r;
        crc_s   = crc_r;
        cnt_s   = cnt_r;
        if (clr) begin
            state_s = ST_RUN;
            crc_s   = INIT_C;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (in_valid) begin
                        crc_s = step_s;
                    end else begin
                        crc_s = crc_r;
                    end
                    if (start_out) begin
                        state_s = ST_SHIFT;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_SHIFT: begin
                    if (out_ready) begin
                        if (cnt_r == CNT_LAST) begin
                            state_s = ST_RUN;
                            crc_s   = INIT_C;
                            cnt_s   = {CNT_W{1'b0}};
                        end else begin
                            crc_s = crc_r >> 1;
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        crc_s = crc_r;
                    end
                end
                default: begin
                    state_s = ST_RUN;
                    crc_s   = INIT_C;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, CRC and bit-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            crc_r   <= INIT_C;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            crc_r   <= crc_s;
            cnt_r   <= cnt_s;
        end
    end

    assign in_ready   = (state_r == ST_RUN);
    assign out_valid  = (state_r == ST_SHIFT);
    assign out_last   = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
    assign serial_out = crc_r[0];
    assign crc_out    = crc_r;

`ifdef ADBG_CRC_MATCH_EN
    logic match_seen_r;

    assign crc_match  = (crc_r == {CRC_W{1'b0}});
    assign match_seen = match_seen_r;

    // Sticky record of a zero residue seen while accumulating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_seen_r <= 1'b0;
        end else if (clr) begin
            match_seen_r <= 1'b0;
        end else if ((state_r == ST_RUN) && crc_match) begin
            match_seen_r <= 1'b1;
        end else begin
            match_seen_r <= match_seen_r;
        end
    end
`endif

endmodule

// File: tb/tb_adbg_crc_engine.sv
// Self-checking bench for adbg_crc_engine: vector table, check-value
// sequences at DATA_W 8/32/1, serialiser corners and randomized beats.
module tb_adbg_crc_engine;

    localparam logic [31:0] POLY = 32'hEDB88320;
    localparam logic [31:0] INIT = 32'hFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, zero_s;
    logic        in_valid, start_out, out_ready;
    logic [7:0]  in_data;
    logic [3:0]  in_nbits;
    logic        in_ready, out_valid, serial_out, out_last;
    logic [31:0] crc_out;

    logic        v32, v1, d1, n1;
    logic [31:0] d32;
    logic [5:0]  n32;
    logic        rdy32, ov32, so32, ol32, rdy1, ov1, so1, ol1;
    logic [31:0] crc32, crc1;

`ifdef ADBG_CRC_MATCH_EN
    logic m8, ms8, m32, ms32, m1, ms1;
`endif

    adbg_crc_engine #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_nbits(in_nbits), .start_out(start_out),
        .out_valid(out_valid), .out_ready(out_ready), .serial_out(serial_out),
        .out_last(out_last), .crc_out(crc_out)
`ifdef ADBG_CRC_MATCH_EN
        , .crc_match(m8), .match_seen(ms8)
`endif
    );

    adbg_crc_engine #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(v32), .in_ready(rdy32),
        .in_data(d32), .in_nbits(n32), .start_out(zero_s),
        .out_valid(ov32), .out_ready(zero_s), .serial_out(so32),
        .out_last(ol32), .crc_out(crc32)
`ifdef ADBG_CRC_MATCH_EN
        , .crc_match(m32), .match_seen(ms32)
`endif
    );

    adbg_crc_engine #(.DATA_W(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(v1), .in_ready(rdy1),
        .in_data(d1), .in_nbits(n1), .start_out(zero_s),
        .out_valid(ov1), .out_ready(zero_s), .serial_out(so1),
        .out_last(ol1), .crc_out(crc1)
`ifdef ADBG_CRC_MATCH_EN
        , .crc_match(m1), .match_seen(ms1)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  nbits;
        logic [31:0] exp;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] msg [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: apply n bits of d, LSB first, with the reflected polynomial.
    function automatic logic [31:0] ref_bits(input logic [31:0] c, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            c = (d[i] ^ c[0]) ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Collect serial bits from dut (already in ST_SHIFT); mode 0=ready, 1=toggle, 2=random.
    task automatic shift_out(input int mode, output logic [31:0] val, output int nb,
                             output int last_idx, output int last_cnt);
        val = 32'h0; nb = 0; last_idx = -1; last_cnt = 0;
        for (int k = 0; k < 400 && nb < 32; k++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                val[nb] = serial_out;
                if (out_last) begin
                    last_cnt++;
                    last_idx = nb;
                end
                nb++;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    logic [31:0] m, val;
    int nb, last_idx, last_cnt, eff;

    initial begin
        rst = 1'b1; clr = 1'b0; zero_s = 1'b0;
        in_valid = 1'b0; start_out = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_nbits = 4'd0;
        v32 = 1'b0; d32 = 32'h0; n32 = 6'd0; v1 = 1'b0; d1 = 1'b0; n1 = 1'b0;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        tbl[0] = '{8'h00, 4'd8,  32'h2DFD1072};
        tbl[1] = '{8'h00, 4'd0,  32'h2DFD1072};
        tbl[2] = '{8'h00, 4'd12, 32'h2DFD1072};
        tbl[3] = '{8'h01, 4'd1,  32'h7FFFFFFF};
        tbl[4] = '{8'hFE, 4'd1,  32'h92477CDF};
        tbl[5] = '{8'hFF, 4'd2,  32'h3FFFFFFF};
        tbl[6] = '{8'hFD, 4'd1,  32'h7FFFFFFF};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_crc", crc_out, INIT);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_serial", {31'b0, serial_out}, {31'b0, INIT[0]});
`ifdef ADBG_CRC_MATCH_EN
        chk("rst_match", {31'b0, m8}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Single-beat vector table
        for (int i = 0; i < 7; i++) begin
            do_clr();
            in_valid = 1'b1; in_data = tbl[i].data; in_nbits = tbl[i].nbits;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d", i), crc_out, tbl[i].exp);
        end

        // Check string at DATA_W=8, one beat per cycle
        do_clr();
        m = INIT;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = msg[i]; in_nbits = 4'd0;
            tick();
            m = ref_bits(m, {24'h0, msg[i]}, 8);
            chk($sformatf("seq8_%0d", i), crc_out, m);
        end
        in_valid = 1'b0;
        chk("seq8_final", crc_out, 32'h340BC6D9);

        // Serialise with out_ready toggling, in_valid held and stalled
        start_out = 1'b1;
        tick();
        start_out = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA; in_nbits = 4'd0;
        chk("shift_in_ready", {31'b0, in_ready}, 32'd0);
        chk("shift_out_valid", {31'b0, out_valid}, 32'd1);
        shift_out(1, val, nb, last_idx, last_cnt);
        chk("shift_bits", val, 32'h340BC6D9);
        chk("shift_nbits", nb, 32);
        chk("shift_last_cnt", last_cnt, 1);
        chk("shift_last_idx", last_idx, 31);
        chk("shift_after_crc", crc_out, INIT);
        chk("shift_after_ready", {31'b0, in_ready}, 32'd1);
        chk("shift_after_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;

        // Beat and start_out in the same cycle: beat is included
        do_clr();
        in_valid = 1'b1; in_data = 8'h00; in_nbits = 4'd8; start_out = 1'b1;
        tick();
        in_valid = 1'b0; start_out = 1'b0;
        shift_out(0, val, nb, last_idx, last_cnt);
        chk("absorb_start", val, 32'h2DFD1072);

        // Async reset after 10 shifted bits
        do_clr();
        start_out = 1'b1;
        tick();
        start_out = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        chk("mid_shift_crc", crc_out, 32'h003FFFFF);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_crc", crc_out, INIT);
        chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // clr with a beat discards the beat
        in_valid = 1'b1; in_data = 8'h55; in_nbits = 4'd0; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        chk("clr_beat", crc_out, INIT);

        // clr during shift-out
        in_valid = 1'b1; in_data = 8'h12;
        tick();
        in_valid = 1'b0; start_out = 1'b1;
        tick();
        start_out = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_shift_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_shift_crc", crc_out, INIT);

        // DATA_W=32 with a partial last beat carrying garbage
        do_clr();
        v32 = 1'b1; d32 = 32'h34333231; n32 = 6'd0;
        tick();
        d32 = 32'h38373635; n32 = 6'd32;
        tick();
        d32 = 32'hABCDEF39; n32 = 6'd8;
        tick();
        v32 = 1'b0;
        chk("seq32_final", crc32, 32'h340BC6D9);

        // DATA_W=1: 72 serial bits, then one zero byte
        do_clr();
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8; j++) begin
                v1 = 1'b1; d1 = msg[i][j]; n1 = (j % 2 == 0);
                tick();
            end
        end
        v1 = 1'b0;
        chk("seq1_final", crc1, 32'h340BC6D9);
        do_clr();
        for (int j = 0; j < 8; j++) begin
            v1 = 1'b1; d1 = 1'b0; n1 = 1'b0;
            tick();
        end
        v1 = 1'b0;
        chk("seq1_zero", crc1, 32'h2DFD1072);

        // Randomized beats and random out_ready against the reference
        do_clr();
        m = INIT;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 60; k++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                in_nbits = 4'($urandom_range(0, 15));
                tick();
                if (in_valid) begin
                    eff = (in_nbits == 4'd0 || in_nbits > 4'd8) ? 8 : int'(in_nbits);
                    m = ref_bits(m, {24'h0, in_data}, eff);
                end
                chk("rand_acc", crc_out, m);
            end
            in_valid = 1'b0; start_out = 1'b1;
            tick();
            start_out = 1'b0;
            shift_out(2, val, nb, last_idx, last_cnt);
            chk("rand_shift", val, m);
            chk("rand_shift_last", last_idx, 31);
            m = INIT;
            chk("rand_reload", crc_out, m);
        end

`ifdef ADBG_CRC_MATCH_EN
        // Payload followed by its own CRC leaves a zero residue
        do_clr();
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_nbits = 4'd0;
            in_data = (i < 9) ? msg[i] : 8'(32'h340BC6D9 >> (8 * (i - 9)));
            tick();
        end
        in_valid = 1'b0;
        chk("match_crc", crc_out, 32'h0);
        chk("match_flag", {31'b0, m8}, 32'd1);
        tick();
        chk("match_seen", {31'b0, ms8}, 32'd1);
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        chk("match_gone", {31'b0, m8}, 32'd0);
        chk("match_sticky", {31'b0, ms8}, 32'd1);
        do_clr();
        chk("match_clr", {31'b0, ms8}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
